// File: rtl/screen_pkg.sv
// screen_pkg: shared screen geometry, colour width and frame sequencer states.
package screen_pkg;
    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int PIANO_PIXELS = 4480;
    localparam int COLOUR_W     = 24;
    localparam int ADDR_W       = $clog2(PIANO_PIXELS);
    typedef enum logic [1:0] {IDLE, BG, NOTES, DONE} state_t;
endpackage

// File: rtl/raster_scanner.sv
// raster_scanner: x-fastest 160x120 scan with a piano ROM address that only counts on piano rows.
module raster_scanner
    import screen_pkg::*;
#(
    parameter logic [7:0] PIANO_TOP = 8'd92
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              advance,
    output logic [7:0]        x,
    output logic [7:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1);
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);
    assign step = advance && !last;
    always_comb begin
        x_d    = start ? '0 : step ? ((x_q == X_MAX) ? '0 : x_q + 8'd1) : x_q;
        y_d    = start ? '0 : (step && x_q == X_MAX) ? y_q + 8'd1 : y_q;
        addr_d = start ? '0 : (step && y_q >= PIANO_TOP) ? addr_q + 1'b1 : addr_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end
    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame background raster then note-drawer handoff on one VGA plot port.
// Optional FRAME_OVERRUN_CNT_EN adds a saturating count of frame ticks dropped while busy.
module frame_draw_scheduler
    import screen_pkg::*;
#(
    parameter logic [7:0] PIANO_TOP = 8'd92,
    parameter int         ROM_LAT   = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_tick,
    output logic [ADDR_W-1:0]   piano_addr,
    input  logic [COLOUR_W-1:0] piano_colour,
    input  logic                note_req,
    input  logic [7:0]          note_x,
    input  logic [7:0]          note_y,
    input  logic [COLOUR_W-1:0] note_colour,
    input  logic                note_done,
    output logic                note_grant,
    output logic                plot,
    output logic [7:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                busy,
    output logic                frame_done
`ifdef FRAME_OVERRUN_CNT_EN
    ,
    output logic [7:0]          overrun_count
`endif
);
    state_t              state_q, state_d;
    logic [7:0]          scan_x, scan_y, x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]   scan_addr;
    logic                scan_last, in_bg, accept;
    logic                grant_q, grant_d, plot_q, plot_d, piano_q, piano_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    assign in_bg  = state_q == BG;
    assign accept = grant_q && note_req;
    raster_scanner #(.PIANO_TOP(PIANO_TOP)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .start   (state_q == IDLE && frame_tick),
        .advance (in_bg),
        .x       (scan_x),
        .y       (scan_y),
        .addr    (scan_addr),
        .last    (scan_last)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = frame_tick ? BG : IDLE;
            BG:      state_d = scan_last ? NOTES : BG;
            NOTES:   state_d = (note_done && grant_q) ? DONE : NOTES;
            default: state_d = IDLE;
        endcase
    end
    // Grant lags NOTES entry by one cycle so the last background pixel drains first.
    always_comb begin
        plot_d   = in_bg || accept;
        x_d      = in_bg ? scan_x : accept ? note_x : x_q;
        y_d      = in_bg ? scan_y : accept ? note_y : y_q;
        colour_d = in_bg ? '0 : accept ? note_colour : colour_q;
        piano_d  = in_bg && scan_y >= PIANO_TOP;
        grant_d  = state_q == NOTES && !(note_done && grant_q);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            plot_q   <= 1'b0;
            piano_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            plot_q   <= plot_d;
            piano_q  <= piano_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end
    assign piano_addr = scan_addr;
    assign note_grant = grant_q;
    assign plot       = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = (piano_q && ROM_LAT == 1) ? piano_colour : colour_q;
    assign busy       = state_q == BG || state_q == NOTES;
    assign frame_done = state_q == DONE;
`ifdef FRAME_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;
    assign ovr_d = (frame_tick && busy && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
    always_ff @(posedge clk) begin
        if (!resetn) ovr_q <= '0;
        else         ovr_q <= ovr_d;
    end
    assign overrun_count = ovr_q;
`endif
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: directed checks of background raster, note handoff, reset and dropped ticks.
module tb_frame_draw_scheduler;
    logic        clk = 1'b0;
    logic        resetn, frame_tick, note_req, note_done;
    logic [12:0] piano_addr;
    logic [23:0] piano_colour = '0;
    logic [7:0]  note_x, note_y, vga_x, vga_y;
    logic [23:0] note_colour, vga_colour;
    logic        note_grant, plot, busy, frame_done;
`ifdef FRAME_OVERRUN_CNT_EN
    logic [7:0]  overrun_count;
`endif
    int errors = 0;
    int checks = 0;
    int plots, gap, grant_seen;

    always #5 clk = ~clk;

    function automatic logic [23:0] rom(input logic [12:0] a);
        return 24'hC00000 | {11'd0, a};
    endfunction

    always @(posedge clk) piano_colour <= rom(piano_addr);

    frame_draw_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .piano_addr   (piano_addr),
        .piano_colour (piano_colour),
        .note_req     (note_req),
        .note_x       (note_x),
        .note_y       (note_y),
        .note_colour  (note_colour),
        .note_done    (note_done),
        .note_grant   (note_grant),
        .plot         (plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef FRAME_OVERRUN_CNT_EN
        ,
        .overrun_count(overrun_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_x"}, vga_x, 0);
        check({tag, "_y"}, vga_y, 0);
        check({tag, "_colour"}, vga_colour, 0);
        check({tag, "_addr"}, piano_addr, 0);
        check({tag, "_grant"}, note_grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
    endtask

    initial begin
        resetn = 1'b0; frame_tick = 1'b0; note_req = 1'b0; note_done = 1'b0;
        note_x = '0; note_y = '0; note_colour = '0;
        repeat (3) step();
        check_reset_outputs("rst");
        resetn = 1'b1;
        step();
        // Frame 1: note drawer requests throughout BG and must be ignored.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        note_req = 1'b1; note_done = 1'b1;
        note_x = 8'd77; note_y = 8'd55; note_colour = 24'h123456;
        plots = 0; gap = 0; grant_seen = 0;
        for (int c = 2; c <= 19202; c++) begin
            step();
            frame_tick = (c == 100);
            if (c == 19199) begin note_req = 1'b0; note_done = 1'b0; end
            if (plot) plots++;
            else if (c <= 19201) gap = 1;
            if (note_grant && c < 19202) grant_seen = 1;
            if (c == 2) begin
                check("first_x", vga_x, 0);
                check("first_y", vga_y, 0);
                check("first_colour", vga_colour, 0);
                check("first_plot", plot, 1);
            end
            if (c == 14721) begin
                check("black_end_xy", {vga_x, vga_y}, {8'd159, 8'd91});
                check("black_end_colour", vga_colour, 0);
                check("piano_addr0", piano_addr, 0);
            end
            if (c == 14722) begin
                check("piano_first_xy", {vga_x, vga_y}, {8'd0, 8'd92});
                check("piano_first_colour", vga_colour, rom(13'd0));
            end
            if (c == 19201) begin
                check("bg_last_xy", {vga_x, vga_y}, {8'd159, 8'd119});
                check("bg_last_colour", vga_colour, rom(13'd4479));
                check("grant_drain", note_grant, 0);
            end
            if (c == 19202) begin
                check("grant_rise", note_grant, 1);
                check("plot_after_bg", plot, 0);
            end
        end
        check("bg_plot_count", plots, 19200);
        check("bg_no_gap", gap, 0);
        check("bg_no_grant", grant_seen, 0);
        check("notes_busy", busy, 1);
        for (int c = 19203; c <= 19300; c++) begin
            step();
            frame_tick = (c == 19300);
        end
        step();
        frame_tick = 1'b0;
        check("notes_idle_plot", plot, 0);
        check("tick_dropped_busy", busy, 1);
`ifdef FRAME_OVERRUN_CNT_EN
        check("overrun_2", overrun_count, 2);
`endif
        // Note handoff: three pixels then a final one with note_done.
        note_req = 1'b1; note_x = 8'd10; note_y = 8'd20; note_colour = 24'hFF0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("note_plot", plot, 1);
            check("note_xy", {vga_x, vga_y}, {8'd10, 8'd20});
            check("note_colour", vga_colour, 24'hFF0000);
            check("note_fdone_low", frame_done, 0);
        end
        note_x = 8'd11; note_done = 1'b1;
        step();
        check("final_plot", plot, 1);
        check("final_xy", {vga_x, vga_y}, {8'd11, 8'd20});
        check("frame_done", frame_done, 1);
        check("busy_fall", busy, 0);
        check("grant_fall", note_grant, 0);
        note_req = 1'b0; note_done = 1'b0; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("frame_done_pulse", frame_done, 0);
        check("coincident_tick_dropped", busy, 0);
        check("idle_plot", plot, 0);
`ifdef FRAME_OVERRUN_CNT_EN
        check("overrun_hold", overrun_count, 2);
`endif
        // Reset mid-pass.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 2; c <= 5000; c++) step();
        check("pre_reset_plot", plot, 1);
        resetn = 1'b0;
        step();
        check_reset_outputs("midrst");
        resetn = 1'b1;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 2; c <= 14722; c++) begin
            step();
            frame_tick = (c >= 3 && c <= 302);
            if (c == 2) begin
                check("restart_xy", {vga_x, vga_y}, {8'd0, 8'd0});
                check("restart_plot", plot, 1);
            end
            if (c == 14721) check("restart_addr0", piano_addr, 0);
            if (c == 14722) check("restart_piano_colour", vga_colour, rom(13'd0));
        end
`ifdef FRAME_OVERRUN_CNT_EN
        check("overrun_sat", overrun_count, 255);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
